uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmit engine directly downstream of the 8-deep TX byte FIFO.
//  Pops one byte at a time via the FIFO read handshake and serializes it as an async frame:
//  start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits.
//  Runs on the 3.125 MHz TX clock; tx drives the board UART pin.
// PARAMETERS
//  CLKS_PER_BIT  27  clk cycles per bit (3.125 MHz / 115200 ~= 27); legal range >= 2
//  PARITY_EN     0   1 = insert parity bit after D7
//  PARITY_ODD    0   0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
//  STOP_BITS     1   number of stop bits: 1 or 2
// PORTS
//  clk_3125_tx  in   1  TX clock, rising-edge active
//  reset        in   1  asynchronous, active-high reset
//  ft_empty     in   1  FIFO empty flag
//  ft_out       in   8  FIFO registered output; valid the cycle after the rd_en edge
//  rd_en        out  1  FIFO pop request; exactly one cycle per byte
//  tx           out  1  serial line; idle/stop = 1, start = 0
//  tx_busy      out  1  high whenever state != IDLE
//  tx_done      out  1  one-cycle pulse on completion of the last stop bit
// BEHAVIOUR
//  Reset (async, immediate)
//   - state = IDLE; tx = 1; rd_en = 0; tx_busy = 0; tx_done = 0.
//   - Baud counter, bit index and shift register cleared.
//   - Mid-frame reset aborts the frame; tx returns high without waiting for a clock.
//  Outputs
//   - All outputs are registered, so there are no combinational paths from inputs to outputs.
//  FSM: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP
//   - IDLE: on an edge with ft_empty = 0, go to FETCH. Otherwise stay; tx = 1.
//   - FETCH: rd_en = 1 for exactly this one cycle, then go to LOAD.
//     FETCH is only entered with ft_empty = 0, so rd_en is never issued on an empty FIFO.
//   - LOAD: capture ft_out into the shift register, compute parity, go to START.
//   - START: tx = 0 for CLKS_PER_BIT cycles.
//   - DATA: tx = shreg[0]; shift right every CLKS_PER_BIT cycles.
//     Leave after bit index 7 completes; index is 3 bits, no wrap past 7.
//   - PARITY (only when PARITY_EN = 1): tx = ^data ^ PARITY_ODD for CLKS_PER_BIT cycles.
//   - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
//     On the final cycle, pulse tx_done; next state is IDLE.
//  Baud counter
//   - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, cleared on every state change.
//  Latency and frame length
//   - tx falls 2 clocks after the edge at which IDLE samples ft_empty = 0.
//   - Frame length is exactly (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles, from tx fall to tx_done.
//  Back-to-back bytes
//   - STOP -> IDLE -> FETCH -> LOAD gives a 3-cycle extension of the high stop level.
//   - This is legal (stop is a minimum length). No other gap is allowed.
//  Input stability
//   - ft_empty rising during a frame has no effect on the current frame.
//   - ft_out is sampled only in LOAD.
// STRUCTURE
//  uart_pkg
//   - State encodings as localparams; shared with the future RX path.
//   - UART_CLK_HZ = 3125000, UART_BAUD = 115200, derived CLKS_PER_BIT.
//  Sub-module uart_baud_counter
//   - Parameter CLKS_PER_BIT; inputs clear and enable; output bit_tick.
//   - Reused by the RX side.
//  FSM, shift register and parity stay in this module.
// TESTING
//  - Empty FIFO: ft_empty = 1 for 1000 cycles -> rd_en never high, tx = 1, tx_busy = 0.
//  - 8N1, ft_out = 0xA5:
//    - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 27 cycles.
//    - tx_done pulses 270 cycles after tx falls.
//    - rd_en is high for exactly 1 cycle.
//  - PARITY_EN = 1, PARITY_ODD = 0, byte 0xA5 -> parity bit 0.
//    Same byte with PARITY_ODD = 1 -> parity bit 1. Frame is 297 cycles.
//  - FIFO holding 0x00, 0xFF, 0x55:
//    - Exactly 3 rd_en pulses and 3 tx_done pulses.
//    - Each inter-frame high is 27 + 3 cycles.
//    - Decoded bytes equal the pushed order.
//  - Reset asserted mid-DATA of 0x3C:
//    - tx = 1 and tx_busy = 0 within the same cycle.
//    - After deassert, the next queued byte is sent as a complete, well-formed frame.
//  - STOP_BITS = 2, byte 0x80: stop level lasts 54 cycles; tx_done fires once, at its end.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX serializer and the future RX path.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package uart_pkg;

    // Clocking: 3.125 MHz TX clock driving a 115200 baud line.
    localparam int UART_CLK_HZ       = 3125000;
    localparam int UART_BAUD         = 115200;
    // Integer division gives 27; the resulting 0.5% baud error is well inside UART tolerance.
    localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

    // Frame FSM encodings.
    localparam logic [2:0] UART_ST_IDLE   = 3'd0;
    localparam logic [2:0] UART_ST_FETCH  = 3'd1;
    localparam logic [2:0] UART_ST_LOAD   = 3'd2;
    localparam logic [2:0] UART_ST_START  = 3'd3;
    localparam logic [2:0] UART_ST_DATA   = 3'd4;
    localparam logic [2:0] UART_ST_PARITY = 3'd5;
    localparam logic [2:0] UART_ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = UART_ST_IDLE,
        ST_FETCH  = UART_ST_FETCH,
        ST_LOAD   = UART_ST_LOAD,
        ST_START  = UART_ST_START,
        ST_DATA   = UART_ST_DATA,
        ST_PARITY = UART_ST_PARITY,
        ST_STOP   = UART_ST_STOP
    } uart_state_e;

    // Parity bit for a data byte: even parity when odd = 0, odd parity when odd = 1.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: pulses bit_tick on the last clock of every CLKS_PER_BIT window.
// Latency: bit_tick is combinational from the count, asserted on cycle CLKS_PER_BIT-1 after clear.
// Backpressure: none; counts only while enable is high, clear always wins.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clear     - restart the window at count 0 on the next edge
//   enable    - advance the count; bit_tick is suppressed while low
//   bit_tick  - high during the final cycle of a bit period
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int              CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_tick = enable && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || bit_tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops bytes from the TX FIFO and serializes start/8 data LSB-first/[parity]/stop.
// Latency: tx falls 2 clocks after IDLE sees ft_empty = 0; frame = (10+PARITY_EN+STOP_BITS-1)*CLKS_PER_BIT.
// Backpressure: pulls one byte per frame via a single-cycle rd_en; never pops while a frame is in flight.
// Ports:
//   clk_3125_tx - TX clock, rising edge        reset   - asynchronous, active-high
//   ft_empty    - FIFO empty flag              ft_out  - FIFO data, valid the cycle after rd_en
//   rd_en       - FIFO pop, one cycle per byte tx      - serial line, idle high
//   tx_busy     - high whenever not IDLE       tx_done - one-cycle pulse at end of last stop bit
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_3125_tx,
    input  logic       reset,
    input  logic       ft_empty,
    input  logic [7:0] ft_out,
    output logic       rd_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic       PAR_EN    = (PARITY_EN != 0);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        rd_en_q, rd_en_d;
    logic        tx_busy_q, tx_busy_d;
    logic        tx_done_q, tx_done_d;

    logic        baud_clear;
    logic        baud_enable;
    logic        bit_tick;

    // The bit timer only runs in the states that put a bit on the line.
    assign baud_enable = (state_q == ST_START) || (state_q == ST_DATA) ||
                         (state_q == ST_PARITY) || (state_q == ST_STOP);
    // Every state change starts a fresh bit window.
    assign baud_clear  = (state_d != state_q);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk_3125_tx),
        .rst      (reset),
        .clear    (baud_clear),
        .enable   (baud_enable),
        .bit_tick (bit_tick)
    );

    // Next state, datapath and done pulse.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        tx_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!ft_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // ft_out is valid here: the FIFO registered it on the edge that ended FETCH.
                shreg_d  = ft_out;
                parity_d = uart_parity(ft_out, PAR_ODD);
                state_d  = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // bit_idx is reused to count stop bits.
                if (bit_tick) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = ST_IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            bit_idx_d = '0;
        end
    end

    // Outputs are decoded from the next state so their flops line up with the state flop.
    always_comb begin
        rd_en_d   = (state_d == ST_FETCH);
        tx_busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_3125_tx or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            rd_en_q   <= rd_en_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule
